// File: rtl/input_select_sync.sv
// Source selector for the F-engine front end: debounces the software select
// word and applies a new source on a frame sync (or at once in immediate mode).
// Optional ramp test source is built only when INPUT_SELECT_RAMP_EN is defined.
module input_select_sync #(
  parameter int DATA_WIDTH    = 64,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic [31:0]           ctrl_word,
  input  logic                  sync_in,
  input  logic [DATA_WIDTH-1:0] adc0_data,
  input  logic [DATA_WIDTH-1:0] adc1_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sync_out,
  output logic [1:0]            sel_active,
  output logic                  pending,
  output logic [15:0]           switch_count
);

  localparam int         LANES    = DATA_WIDTH / 8;
  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

  typedef enum logic {IDLE, PEND} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              cand_q, pend_sel_q, pend_sel_d, sel_q, sel_d;
  logic                    imm_q;
  logic [7:0]              stab_q, stab_d;
  logic [15:0]             count_q, count_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d, ramp_word;
  logic                    sync_q;

  // The counter compares against the value about to be registered, so it
  // restarts on the same edge that cand takes a new value.
  always_comb begin
    stab_d = stab_q;
    if (ctrl_word[1:0] != cand_q) begin
      stab_d = 8'd0;
    end else if (stab_q < STAB_MAX) begin
      stab_d = stab_q + 8'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_sel_d = pend_sel_q;
    sel_d      = sel_q;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (stab_q == STAB_MAX && cand_q != sel_q) begin
          state_d    = PEND;
          pend_sel_d = cand_q;
        end
      end
      PEND: begin
        // Cancel is checked first so it wins over a coincident apply.
        if (cand_q != pend_sel_q || cand_q == sel_q) begin
          state_d = IDLE;
        end else if (imm_q || sync_in) begin
          state_d = IDLE;
          sel_d   = pend_sel_q;
          count_d = count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef INPUT_SELECT_RAMP_EN
  logic [7:0] ramp_q, ramp_d, ramp_base;

  always_comb begin
    ramp_base = sync_in ? 8'd0 : ramp_q;
    ramp_d    = ramp_base + 8'(LANES);
    ramp_word = '0;
    for (int k = 0; k < LANES; k++) begin
      ramp_word[8*k +: 8] = ramp_base + 8'(k);
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      ramp_q <= 8'd0;
    end else begin
      ramp_q <= ramp_d;
    end
  end
`else
  assign ramp_word = '0;
`endif

  // Muxing on the next selection makes the sync beat the first new sample.
  always_comb begin
    case (sel_d)
      2'd0:    data_d = adc0_data;
      2'd1:    data_d = adc1_data;
      2'd2:    data_d = ramp_word;
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q    <= IDLE;
      cand_q     <= 2'd0;
      imm_q      <= 1'b0;
      stab_q     <= 8'd0;
      pend_sel_q <= 2'd0;
      sel_q      <= 2'd0;
      count_q    <= 16'd0;
      data_q     <= '0;
      sync_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= ctrl_word[1:0];
      imm_q      <= ctrl_word[4];
      stab_q     <= stab_d;
      pend_sel_q <= pend_sel_d;
      sel_q      <= sel_d;
      count_q    <= count_d;
      data_q     <= data_d;
      sync_q     <= sync_in;
    end
  end

  assign data_out     = data_q;
  assign sync_out     = sync_q;
  assign sel_active   = sel_q;
  assign pending      = (state_q == PEND);
  assign switch_count = count_q;

endmodule

// File: tb/tb_input_select_sync.sv
// Directed bench for input_select_sync (DATA_WIDTH=64, STABLE_CYCLES=4).
// Ramp expectations follow INPUT_SELECT_RAMP_EN; zeros are expected otherwise.
module tb_input_select_sync;

  localparam int DW = 64;

  logic          user_clk = 1'b0;
  logic          user_rst = 1'b1;
  logic [31:0]   ctrl_word = 32'd0;
  logic          sync_in = 1'b0;
  logic [DW-1:0] adc0_data = '0;
  logic [DW-1:0] adc1_data = '0;
  logic [DW-1:0] data_out;
  logic          sync_out;
  logic [1:0]    sel_active;
  logic          pending;
  logic [15:0]   switch_count;

  int checkCount = 0;
  int errorCount = 0;
  logic sawPending;

  input_select_sync #(.DATA_WIDTH(DW), .STABLE_CYCLES(4)) dut (
    .user_clk(user_clk), .user_rst(user_rst), .ctrl_word(ctrl_word),
    .sync_in(sync_in), .adc0_data(adc0_data), .adc1_data(adc1_data),
    .data_out(data_out), .sync_out(sync_out), .sel_active(sel_active),
    .pending(pending), .switch_count(switch_count)
  );

  always #5 user_clk = ~user_clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs are driven and outputs sampled 1ns after the edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge user_clk);
      #1;
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_data"}, data_out, 64'd0);
    checkOutput({tag, "_sync"}, {63'd0, sync_out}, 64'd0);
    checkOutput({tag, "_sel"}, {62'd0, sel_active}, 64'd0);
    checkOutput({tag, "_pend"}, {63'd0, pending}, 64'd0);
    checkOutput({tag, "_cnt"}, {48'd0, switch_count}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with arbitrary inputs
    ctrl_word = 32'h0000_0013;
    sync_in   = 1'b1;
    adc0_data = 64'hDEAD_BEEF_0123_4567;
    adc1_data = 64'hFEED_FACE_89AB_CDEF;
    applyStimulus(3);
    checkIdleZero("reset");

    // Release: first beat is ADC0 from the previous cycle
    ctrl_word = 32'd0;
    sync_in   = 1'b0;
    adc0_data = 64'h1111_2222_3333_4444;
    adc1_data = 64'hAAAA_BBBB_CCCC_DDDD;
    user_rst  = 1'b0;
    applyStimulus(1);
    checkOutput("release_adc0", data_out, 64'h1111_2222_3333_4444);
    applyStimulus(4);

    // Glitch: three cycles of source 2, then back to 0
    sawPending = 1'b0;
    ctrl_word = 32'd2;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      sawPending |= pending;
    end
    ctrl_word = 32'd0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      sawPending |= pending;
    end
    checkOutput("glitch_pend", {63'd0, sawPending}, 64'd0);
    checkOutput("glitch_cnt", {48'd0, switch_count}, 64'd0);

    // Sync-gated switch to ADC1
    ctrl_word = 32'd1;
    applyStimulus(5);
    checkOutput("sw_pend_early", {63'd0, pending}, 64'd0);
    applyStimulus(1);
    checkOutput("sw_pend_rise", {63'd0, pending}, 64'd1);
    applyStimulus(10);
    checkOutput("sw_wait_pend", {63'd0, pending}, 64'd1);
    checkOutput("sw_wait_sel", {62'd0, sel_active}, 64'd0);
    checkOutput("sw_wait_data", data_out, 64'h1111_2222_3333_4444);
    adc1_data = 64'h0BAD_CAFE_5555_6666;
    sync_in   = 1'b1;
    applyStimulus(1);
    sync_in   = 1'b0;
    checkOutput("sw_sel", {62'd0, sel_active}, 64'd1);
    checkOutput("sw_sync_out", {63'd0, sync_out}, 64'd1);
    checkOutput("sw_data", data_out, 64'h0BAD_CAFE_5555_6666);
    checkOutput("sw_cnt", {48'd0, switch_count}, 64'd1);
    checkOutput("sw_pend_drop", {63'd0, pending}, 64'd0);
    adc1_data = 64'h7777_8888_9999_0000;
    applyStimulus(1);
    checkOutput("sw_latency", data_out, 64'h7777_8888_9999_0000);
    checkOutput("sw_sync_low", {63'd0, sync_out}, 64'd0);

    // Cancel versus sync: cand changes in the sync cycle
    ctrl_word = 32'd0;
    applyStimulus(6);
    checkOutput("cx_pend", {63'd0, pending}, 64'd1);
    ctrl_word = 32'd3;
    applyStimulus(1);
    checkOutput("cx_pend_hold", {63'd0, pending}, 64'd1);
    sync_in = 1'b1;
    applyStimulus(1);
    sync_in = 1'b0;
    checkOutput("cx_sel", {62'd0, sel_active}, 64'd1);
    checkOutput("cx_pend_drop", {63'd0, pending}, 64'd0);
    checkOutput("cx_cnt", {48'd0, switch_count}, 64'd1);
    checkOutput("cx_data", data_out, 64'h7777_8888_9999_0000);

    // Immediate mode to source 2
    ctrl_word = 32'h12;
    applyStimulus(6);
    checkOutput("imm_pend", {63'd0, pending}, 64'd1);
    checkOutput("imm_sel_old", {62'd0, sel_active}, 64'd1);
    applyStimulus(1);
    checkOutput("imm_sel", {62'd0, sel_active}, 64'd2);
    checkOutput("imm_cnt", {48'd0, switch_count}, 64'd2);
    checkOutput("imm_pend_drop", {63'd0, pending}, 64'd0);

    // Ramp after sync (zeros when the ramp is not built)
    applyStimulus(3);
    sync_in = 1'b1;
    applyStimulus(1);
    sync_in = 1'b0;
    checkOutput("ramp_sync_out", {63'd0, sync_out}, 64'd1);
`ifdef INPUT_SELECT_RAMP_EN
    checkOutput("ramp_beat0", data_out, 64'h0706_0504_0302_0100);
    applyStimulus(1);
    checkOutput("ramp_beat1", data_out, 64'h0F0E_0D0C_0B0A_0908);
    applyStimulus(30);
    checkOutput("ramp_beat31", data_out, 64'hFFFE_FDFC_FBFA_F9F8);
    applyStimulus(1);
    checkOutput("ramp_wrap", data_out, 64'h0706_0504_0302_0100);
`else
    checkOutput("zero_beat0", data_out, 64'd0);
    applyStimulus(1);
    checkOutput("zero_beat1", data_out, 64'd0);
`endif

    // Reset during PEND discards the request
    ctrl_word = 32'd1;
    applyStimulus(6);
    checkOutput("rp_pend", {63'd0, pending}, 64'd1);
    user_rst = 1'b1;
    #1;
    checkIdleZero("rp_reset");
    applyStimulus(1);
    user_rst = 1'b0;
    applyStimulus(5);
    checkOutput("rp_pend_early", {63'd0, pending}, 64'd0);
    applyStimulus(1);
    checkOutput("rp_pend_again", {63'd0, pending}, 64'd1);
    checkOutput("rp_sel", {62'd0, sel_active}, 64'd0);
    checkOutput("rp_cnt", {48'd0, switch_count}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
